// File: rtl/conv_ctrl_if.sv
// Result stream between the convolution controller and its downstream consumer.
// out_data is held stable while out_valid is high until out_ready accepts it.
interface conv_ctrl_if;
    logic signed [7:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/conv_ctrl.sv
// Sequencer for a K-tap convolution MAC: walks signal/weight buffer addresses per output
// pixel, drives the MAC strobes, captures the saturated result and hands it downstream.
module conv_ctrl #(
    parameter int K       = 9,
    parameter int MAC_LAT = 2,
    parameter int AW      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [15:0]         n_out,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       sig_addr,
    output logic [7:0]          wgt_addr,
    output logic                clken,
    output logic                s_convout,
    output logic                en_sat,
    output logic                en_mult_r,
    input  logic signed [7:0]   convout,
    conv_ctrl_if.master         out_if
);

    typedef enum logic [2:0] {IDLE, FETCH, TAP, DRAIN, SAT, CAPT, OUT} state_t;

    localparam logic [7:0]    T_LAST = 8'(K - 1);
    localparam logic [3:0]    D_LAST = 4'(MAC_LAT > 0 ? MAC_LAT - 1 : 0);
    localparam logic [AW-1:0] K_AW   = AW'(K);

    state_t            state, state_nxt;
    logic [15:0]       n_lat;
    logic [15:0]       p;
    logic [7:0]        t;
    logic [3:0]        d;
    logic [AW-1:0]     base;
    logic signed [7:0] out_data_q;
    logic              out_valid;
    logic              last_tap;
    logic              last_drain;
    logic              last_pix;
    logic              handshake;

    assign last_tap   = (t == T_LAST);
    assign last_drain = (d == D_LAST);
    assign last_pix   = ((p + 16'd1) == n_lat);
    assign handshake  = out_valid && out_if.out_ready;

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid;
    assign en_mult_r        = busy;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        clken     = 1'b0;
        s_convout = 1'b0;
        en_sat    = 1'b0;
        out_valid = 1'b0;
        sig_addr  = '0;
        wgt_addr  = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && (n_out != 16'd0)) state_nxt = FETCH;
            end
            FETCH: begin
                sig_addr  = base;
                state_nxt = TAP;
            end
            // Addresses run one tap ahead to cover the 1-cycle buffer read latency.
            TAP: begin
                clken     = 1'b1;
                s_convout = (t == 8'd0);
                sig_addr  = base + AW'(t) + AW'(1);
                wgt_addr  = t + 8'd1;
                if (last_tap) state_nxt = (MAC_LAT == 0) ? SAT : DRAIN;
            end
            DRAIN: begin
                if (last_drain) state_nxt = SAT;
            end
            SAT: begin
                en_sat    = 1'b1;
                state_nxt = CAPT;
            end
            CAPT: begin
                en_sat    = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_if.out_ready) state_nxt = last_pix ? IDLE : FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, pixel base address (p*K kept incrementally, wrapping at 2^AW) and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_lat      <= '0;
            p          <= '0;
            t          <= '0;
            d          <= '0;
            base       <= '0;
            out_data_q <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (n_out == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            n_lat <= n_out;
                            p     <= '0;
                            t     <= '0;
                            base  <= '0;
                        end
                    end
                end
                FETCH: begin
                    t <= '0;
                    d <= '0;
                end
                TAP: begin
                    t <= last_tap ? 8'd0 : t + 8'd1;
                end
                DRAIN: begin
                    d <= d + 4'd1;
                end
                CAPT: begin
                    out_data_q <= convout;
                end
                OUT: begin
                    if (handshake) begin
                        if (last_pix) begin
                            p    <= '0;
                            base <= '0;
                            done <= 1'b1;
                        end else begin
                            p    <= p + 16'd1;
                            base <= base + K_AW;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed bench for conv_ctrl: a small MAC model reads buffers where signal = pixel+1
// and weight = tap+1, so each pixel result is (pixel+1)*45, saturated to 127.
module tb_conv_ctrl;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [15:0]       n_out;
    logic              busy, done, clken, s_convout, en_sat, en_mult_r;
    logic [15:0]       sig_addr;
    logic [7:0]        wgt_addr;
    logic signed [7:0] convout;

    logic              start8;
    logic [15:0]       n_out8;
    logic              busy8, done8, clken8, s_convout8, en_sat8, en_mult_r8;
    logic [7:0]        sig_addr8;
    logic [7:0]        wgt_addr8;
    logic signed [7:0] convout8;

    conv_ctrl_if oif ();
    conv_ctrl_if oif8 ();

    conv_ctrl #(.K(9), .MAC_LAT(2), .AW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .n_out(n_out),
        .busy(busy), .done(done), .sig_addr(sig_addr), .wgt_addr(wgt_addr),
        .clken(clken), .s_convout(s_convout), .en_sat(en_sat), .en_mult_r(en_mult_r),
        .convout(convout), .out_if(oif.master)
    );

    conv_ctrl #(.K(9), .MAC_LAT(2), .AW(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .n_out(n_out8),
        .busy(busy8), .done(done8), .sig_addr(sig_addr8), .wgt_addr(wgt_addr8),
        .clken(clken8), .s_convout(s_convout8), .en_sat(en_sat8), .en_mult_r(en_mult_r8),
        .convout(convout8), .out_if(oif8.master)
    );

    always #5 clk = ~clk;

    // MAC model: registered buffer reads, accumulate on clken, restart on s_convout.
    int         acc = 0;
    logic [7:0] sig_rd = 8'd0;
    logic [7:0] wgt_rd = 8'd0;
    always @(posedge clk) begin
        sig_rd <= 8'(int'(sig_addr) / 9 + 1);
        wgt_rd <= wgt_addr + 8'd1;
        if (clken) acc <= s_convout ? int'(sig_rd) * int'(wgt_rd)
                                    : acc + int'(sig_rd) * int'(wgt_rd);
    end
    always_comb begin
        convout = 8'sd0;
        if (acc > 127)       convout = 8'sd127;
        else if (acc < -128) convout = -8'sd128;
        else                 convout = 8'(acc);
    end
    assign convout8 = 8'sd0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, ck, sc, sc_at, ov_at, od, dn_at, dcnt, es, busy_low, bad, chg, ovlow;
        int prev_sa, prev8, dn8;
        logic prev_ov;
        logic signed [7:0] held;
        int base_q[$];
        int ov_q[$];
        int od_q[$];
        int base8_q[$];

        reset = 1'b1; start = 1'b0; n_out = 16'd0;
        start8 = 1'b0; n_out8 = 16'd0;
        oif.out_ready = 1'b0; oif8.out_ready = 1'b1;
        repeat (3) step();
        chk("rst_ctrl", 32'({busy, done, clken, s_convout, en_sat, en_mult_r, oif.out_valid}), 0);
        chk("rst_sig_addr", 32'(sig_addr), 0);
        chk("rst_wgt_addr", 32'(wgt_addr), 0);
        chk("rst_out_data", 32'(oif.out_data), 0);
        reset = 1'b0;
        step();

        // Single pixel, full handshake timing.
        oif.out_ready = 1'b1; n_out = 16'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("A_fetch_busy", 32'(busy), 1);
        chk("A_fetch_sig", 32'(sig_addr), 0);
        chk("A_fetch_wgt", 32'(wgt_addr), 0);
        chk("A_fetch_clken", 32'(clken), 0);
        ck = 0; sc = 0; sc_at = -1; ov_at = -1; dn_at = -1; dcnt = 0; es = 0;
        for (n = 0; n <= 20; n++) begin
            if (n > 0) step();
            if (clken) begin
                ck++;
                chk("A_wgt_prefetch", 32'(wgt_addr), n);
            end
            if (s_convout) begin
                sc++;
                if (sc_at < 0) sc_at = n;
            end
            if (en_sat) es++;
            if (oif.out_valid && ov_at < 0) begin
                ov_at = n;
                chk("A_out_data", 32'(oif.out_data), 45);
            end
            if (done) begin
                dcnt++;
                if (dn_at < 0) dn_at = n;
            end
        end
        chk("A_clken_cycles", ck, 9);
        chk("A_sconv_count", sc, 1);
        chk("A_sconv_at", sc_at, 1);
        chk("A_en_sat_cycles", es, 2);
        chk("A_first_valid", ov_at, 14);
        chk("A_done_at", dn_at, 15);
        chk("A_done_count", dcnt, 1);
        chk("A_idle_busy", 32'(busy), 0);
        chk("A_idle_mult_r", 32'(en_mult_r), 0);

        // Three pixels back to back; a second start mid-job must be ignored.
        n_out = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        prev_sa = int'(sig_addr); prev_ov = 1'b0; dn_at = -1; busy_low = 0;
        for (n = 0; n <= 60; n++) begin
            if (n > 0) step();
            if (n == 5) begin n_out = 16'd5; start = 1'b1; end
            if (n == 6) start = 1'b0;
            if (s_convout) base_q.push_back(prev_sa);
            if (oif.out_valid && !prev_ov) begin
                ov_q.push_back(n);
                od_q.push_back(int'(oif.out_data));
            end
            if (done && dn_at < 0) dn_at = n;
            if (dn_at < 0 && (!busy || en_mult_r !== busy)) busy_low++;
            prev_sa = int'(sig_addr);
            prev_ov = oif.out_valid;
        end
        chk("B_pixels", base_q.size(), 3);
        chk("B_base0", base_q[0], 0);
        chk("B_base1", base_q[1], 9);
        chk("B_base2", base_q[2], 18);
        chk("B_valids", ov_q.size(), 3);
        chk("B_valid0", ov_q[0], 14);
        chk("B_valid1", ov_q[1], 29);
        chk("B_valid2", ov_q[2], 44);
        chk("B_data0", od_q[0], 45);
        chk("B_data1", od_q[1], 90);
        chk("B_data2_sat", od_q[2], 127);
        chk("B_done_at", dn_at, 45);
        chk("B_busy_gaps", busy_low, 0);

        // Backpressure: hold out_ready low for 20 cycles on the first result.
        oif.out_ready = 1'b0; n_out = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (n = 0; n < 40 && !oif.out_valid; n++) step();
        chk("C_first_valid", n, 14);
        held = oif.out_data;
        chk("C_data", 32'(held), 45);
        ck = 0; chg = 0; ovlow = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (clken) ck++;
            if (oif.out_data !== held) chg++;
            if (!oif.out_valid) ovlow++;
        end
        chk("C_hold_clken", ck, 0);
        chk("C_hold_data", chg, 0);
        chk("C_hold_valid", ovlow, 0);
        oif.out_ready = 1'b1;
        step();
        chk("C_fetch_base", 32'(sig_addr), 9);
        chk("C_fetch_valid", 32'(oif.out_valid), 0);
        chk("C_fetch_clken", 32'(clken), 0);
        chk("C_fetch_busy", 32'(busy), 1);
        step();
        chk("C_tap0_sconv", 32'(s_convout), 1);
        chk("C_tap0_sig", 32'(sig_addr), 10);
        for (n = 1; n < 40 && !oif.out_valid; n++) step();
        chk("C_second_valid", n, 14);
        chk("C_second_data", 32'(oif.out_data), 90);
        step();
        chk("C_done", 32'(done), 1);
        chk("C_done_busy", 32'(busy), 0);

        // Zero-length job.
        n_out = 16'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("D_done", 32'(done), 1);
        chk("D_busy", 32'(busy), 0);
        chk("D_clken", 32'(clken), 0);
        step();
        chk("D_done_pulse", 32'(done), 0);
        chk("D_busy_after", 32'(busy), 0);

        // Reset mid-tap, reset over start, then a clean job.
        n_out = 16'd1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("E_tap4_wgt", 32'(wgt_addr), 5);
        chk("E_tap4_clken", 32'(clken), 1);
        reset = 1'b1;
        step();
        chk("E_rst_ctrl", 32'({busy, done, clken, s_convout, en_sat, en_mult_r, oif.out_valid}), 0);
        chk("E_rst_sig", 32'(sig_addr), 0);
        chk("E_rst_wgt", 32'(wgt_addr), 0);
        chk("E_rst_data", 32'(oif.out_data), 0);
        start = 1'b1;
        step();
        chk("E_rst_priority", 32'(busy), 0);
        reset = 1'b0; start = 1'b0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (done || oif.out_valid || busy) bad++;
        end
        chk("E_no_stray", bad, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        ck = 0; sc_at = -1; ov_at = -1; od = -1; dn_at = -1;
        for (n = 0; n <= 18; n++) begin
            if (n > 0) step();
            if (clken) ck++;
            if (s_convout && sc_at < 0) sc_at = n;
            if (oif.out_valid && ov_at < 0) begin
                ov_at = n;
                od = int'(oif.out_data);
            end
            if (done && dn_at < 0) dn_at = n;
        end
        chk("E_clken_cycles", ck, 9);
        chk("E_sconv_at", sc_at, 1);
        chk("E_first_valid", ov_at, 14);
        chk("E_data", od, 45);
        chk("E_done_at", dn_at, 15);

        // 8-bit address instance: bases wrap modulo 256 without stalling.
        n_out8 = 16'd30; start8 = 1'b1;
        step();
        start8 = 1'b0;
        prev8 = int'(sig_addr8); dn8 = -1;
        for (n = 0; n <= 500; n++) begin
            if (n > 0) step();
            if (n == 423) chk("F_addr_255", 32'(sig_addr8), 255);
            if (n == 424) chk("F_addr_wrap", 32'(sig_addr8), 0);
            if (s_convout8) base8_q.push_back(prev8);
            if (done8 && dn8 < 0) dn8 = n;
            prev8 = int'(sig_addr8);
        end
        chk("F_pixels", base8_q.size(), 30);
        chk("F_base27", base8_q[27], 243);
        chk("F_base28", base8_q[28], 252);
        chk("F_base29", base8_q[29], 5);
        chk("F_done_at", dn8, 450);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
